// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data memory.
// Stores are captured in one cycle and drained while the memory port is idle.
// A younger load to a buffered address is answered from the buffer (youngest
// match wins). The pipeline stalls only when a store meets a full buffer.
// Optional feature macro: STORE_BUFFER_COALESCE_EN. When defined, a store that
// hits a buffered address overwrites that entry's data in place, unless the
// hit is the head entry being drained in the same cycle.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_mem_read,
   input  logic                     cpu_mem_write,
   input  logic [AW-1:0]            cpu_addr,
   input  logic [DW-1:0]            cpu_wdata,
   output logic [DW-1:0]            cpu_rdata,
   output logic                     stall,
   output logic                     MemRead,
   output logic                     MemWrite,
   output logic [AW-1:0]            Address,
   output logic [DW-1:0]            WriteData,
   input  logic [DW-1:0]            ReadData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          hit_s;
   logic [PW-1:0] hit_idx_s;
   logic          full_s;
   logic          coalesce_s;
   logic          push_s;
   logic          pop_s;

   assign full_s = (count_q == CNT_FULL);
   assign count  = count_q;
   assign empty  = (count_q == {CW{1'b0}});

   // Find the youngest valid entry whose address matches cpu_addr.
   always_comb begin
      hit_s     = 1'b0;
      hit_idx_s = {PW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == cpu_addr)) begin
            hit_s     = 1'b1;
            hit_idx_s = head_q + PW'(k);
         end else begin
            hit_s     = hit_s;
            hit_idx_s = hit_idx_s;
         end
      end
   end

   // Decide whether a store merges into an existing entry.
   always_comb begin
`ifdef STORE_BUFFER_COALESCE_EN
      // A full buffer whose only match is the head must drain it, so the
      // store cannot merge there and falls back to stall-and-allocate.
      coalesce_s = hit_s && !(full_s && (hit_idx_s == head_q));
`else
      coalesce_s = 1'b0;
`endif
   end

   // Memory-port arbitration, cpu outputs and next-state computation.
   always_comb begin
      cpu_rdata = {DW{1'b0}};
      stall     = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = {AW{1'b0}};
      WriteData = {DW{1'b0}};
      push_s    = 1'b0;
      pop_s     = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;

      if (cpu_mem_write) begin
         // Store (also covers read+write, which returns zero read data).
         if (coalesce_s) begin
            data_d[hit_idx_s] = cpu_wdata;
         end else if (full_s) begin
            stall     = 1'b1;
            pop_s     = 1'b1;
            MemWrite  = 1'b1;
            Address   = addr_q[head_q];
            WriteData = data_q[head_q];
         end else begin
            push_s         = 1'b1;
            addr_d[tail_q] = cpu_addr;
            data_d[tail_q] = cpu_wdata;
         end
      end else if (cpu_mem_read) begin
         // Load: forward from buffer on hit, otherwise read memory.
         if (hit_s) begin
            cpu_rdata = data_q[hit_idx_s];
         end else begin
            MemRead   = 1'b1;
            Address   = cpu_addr;
            cpu_rdata = ReadData;
         end
      end else if (!empty) begin
         // Idle port: drain the oldest entry.
         pop_s     = 1'b1;
         MemWrite  = 1'b1;
         Address   = addr_q[head_q];
         WriteData = data_q[head_q];
      end else begin
         pop_s = 1'b0;
      end

      head_d  = pop_s  ? (head_q + PTR_ONE) : head_q;
      tail_d  = push_s ? (tail_q + PTR_ONE) : tail_q;
      if (push_s) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Pointer and occupancy registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= {PW{1'b0}};
         tail_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful while counted as valid.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=DW=32).
// Expectations follow STORE_BUFFER_COALESCE_EN when it is defined.
module tb_store_buffer;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          cpu_mem_read;
   logic          cpu_mem_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          stall;
   logic          MemRead;
   logic          MemWrite;
   logic [AW-1:0] Address;
   logic [DW-1:0] WriteData;
   logic [DW-1:0] ReadData;
   logic [2:0]    count;
   logic          empty;

   logic [DW-1:0] mem [64];
   int vectors;
   int fails;

   store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .stall(stall), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
      .count(count), .empty(empty)
   );

   // Clock generator.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational data memory model.
   assign ReadData = MemRead ? mem[Address[5:0]] : {DW{1'bz}};

   // Memory write port.
   always @(posedge clk) begin
      if (MemWrite) mem[Address[5:0]] <= WriteData;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
      cpu_addr = 32'd0; cpu_wdata = 32'd0;
      #1;
   endtask

   task automatic set_store(input logic [31:0] a, input logic [31:0] d);
      cpu_mem_read = 1'b0; cpu_mem_write = 1'b1;
      cpu_addr = a; cpu_wdata = d;
      #1;
   endtask

   task automatic set_load(input logic [31:0] a);
      cpu_mem_read = 1'b1; cpu_mem_write = 1'b0;
      cpu_addr = a; cpu_wdata = 32'd0;
      #1;
   endtask

   task automatic drain_all();
      set_idle();
      for (int i = 0; i < 8; i++) begin
         if (count != 3'd0) tick();
      end
      check("drain_empty", {63'd0, empty}, 64'd1);
   endtask

   initial begin
      logic [2:0] dup_count;
      vectors = 0;
      fails   = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[20] = 32'h5;
`ifdef STORE_BUFFER_COALESCE_EN
      dup_count = 3'd1;
`else
      dup_count = 3'd2;
`endif

      // Reset state.
      rst = 1'b0;
      cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
      cpu_addr = 32'd0; cpu_wdata = 32'd0;
      #1;
      check("rst_count", {61'd0, count}, 64'd0);
      check("rst_empty", {63'd0, empty}, 64'd1);
      check("rst_memwrite", {63'd0, MemWrite}, 64'd0);
      check("rst_memread", {63'd0, MemRead}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_rdata", {32'd0, cpu_rdata}, 64'd0);
      #11;
      rst = 1'b1;
      tick();

      // Store then idle drain.
      set_store(32'd10, 32'hAA);
      check("st_stall", {63'd0, stall}, 64'd0);
      check("st_nomem", {63'd0, MemWrite}, 64'd0);
      tick();
      check("st_count1", {61'd0, count}, 64'd1);
      set_idle();
      check("drain_we", {63'd0, MemWrite}, 64'd1);
      check("drain_addr", {32'd0, Address}, 64'd10);
      check("drain_data", {32'd0, WriteData}, 64'hAA);
      tick();
      check("drain_count0", {61'd0, count}, 64'd0);
      check("drain_empty1", {63'd0, empty}, 64'd1);
      check("mem10", {32'd0, mem[10]}, 64'hAA);

      // Store-to-load forwarding.
      set_store(32'd5, 32'h1234);
      tick();
      set_load(32'd5);
      check("fwd_rdata", {32'd0, cpu_rdata}, 64'h1234);
      check("fwd_memread", {63'd0, MemRead}, 64'd0);
      check("fwd_nodrain", {63'd0, MemWrite}, 64'd0);
      tick();
      check("fwd_count", {61'd0, count}, 64'd1);
      set_idle();
      check("fwd_drain_we", {63'd0, MemWrite}, 64'd1);
      check("fwd_drain_addr", {32'd0, Address}, 64'd5);
      tick();
      check("fwd_count0", {61'd0, count}, 64'd0);

      // Duplicate-address stores, youngest forwarded.
      set_store(32'd7, 32'h11);
      tick();
      set_store(32'd7, 32'h22);
      tick();
      set_load(32'd7);
      check("dup_rdata", {32'd0, cpu_rdata}, 64'h22);
      check("dup_count", {61'd0, count}, {61'd0, dup_count});
      tick();
      drain_all();
      check("mem7", {32'd0, mem[7]}, 64'h22);

      // Fill, stall with head drain, then ordered drains.
      for (int a = 0; a < 4; a++) begin
         set_store(a, 32'h100 + a);
         check("fill_stall", {63'd0, stall}, 64'd0);
         tick();
      end
      check("full_count", {61'd0, count}, 64'd4);
      set_store(32'd4, 32'h104);
      check("full_stall", {63'd0, stall}, 64'd1);
      check("full_we", {63'd0, MemWrite}, 64'd1);
      check("full_addr", {32'd0, Address}, 64'd0);
      check("full_data", {32'd0, WriteData}, 64'h100);
      tick();
      check("full_count3", {61'd0, count}, 64'd3);
      check("held_stall", {63'd0, stall}, 64'd0);
      check("held_nowe", {63'd0, MemWrite}, 64'd0);
      tick();
      check("held_count4", {61'd0, count}, 64'd4);
      set_idle();
      for (int a = 1; a <= 4; a++) begin
         check("order_we", {63'd0, MemWrite}, 64'd1);
         check("order_addr", {32'd0, Address}, a);
         check("order_data", {32'd0, WriteData}, 64'h100 + a);
         tick();
      end
      check("order_empty", {63'd0, empty}, 64'd1);

      // Load miss with entries buffered.
      set_store(32'd30, 32'h30);
      tick();
      set_store(32'd31, 32'h31);
      tick();
      set_store(32'd32, 32'h32);
      tick();
      set_load(32'd20);
      check("miss_memread", {63'd0, MemRead}, 64'd1);
      check("miss_addr", {32'd0, Address}, 64'd20);
      check("miss_rdata", {32'd0, cpu_rdata}, 64'h5);
      check("miss_nowe", {63'd0, MemWrite}, 64'd0);
      tick();
      check("miss_count", {61'd0, count}, 64'd3);

      // Asynchronous reset mid-cycle discards buffered stores.
      set_idle();
      #1;
      rst = 1'b0;
      #1;
      check("arst_count", {61'd0, count}, 64'd0);
      check("arst_empty", {63'd0, empty}, 64'd1);
      check("arst_nowe", {63'd0, MemWrite}, 64'd0);
      rst = 1'b1;
      #1;
      check("post_nowe", {63'd0, MemWrite}, 64'd0);
      set_load(32'd30);
      check("post_memread", {63'd0, MemRead}, 64'd1);
      check("post_addr", {32'd0, Address}, 64'd30);
      check("post_rdata", {32'd0, cpu_rdata}, 64'd0);
      tick();

      // Read and write together behave as a store.
      cpu_mem_read = 1'b1; cpu_mem_write = 1'b1;
      cpu_addr = 32'd40; cpu_wdata = 32'h4040;
      #1;
      check("rw_rdata", {32'd0, cpu_rdata}, 64'd0);
      check("rw_memread", {63'd0, MemRead}, 64'd0);
      tick();
      check("rw_count", {61'd0, count}, 64'd1);
      drain_all();
      check("mem40", {32'd0, mem[40]}, 64'h4040);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
